mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access stage of the 5-stage 16-bit pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Drives a single-port data memory through a req/ack handshake with variable latency.
- Stalls the upstream pipeline while an access is outstanding.
- Registers results into the MEM/WB boundary (readData, ALU result, nextPC, writeReg, regWrite, memToReg) for writeback.

Parameters:
DATA_W, 16, datapath / address width
REG_W, 3, register-file index width
MAX_WAIT, 15, cycles in WAIT without memAck before abort (1..15, 4-bit counter)

Ports:
clk  input  1  pipeline clock
rst  input  1  reset; asynchronous, active-high
readData2  input  DATA_W  store data from EX/MEM
ALURes  input  DATA_W  effective address / ALU result from EX/MEM
nextPC  input  DATA_W  PC+2 from EX/MEM
writeReg  input  REG_W  destination register
regWrite, memToReg, memRead, memWrite  input  1 each  control from EX/MEM
memReq  output  1  data-memory request
memWe  output  1  1 = write, 0 = read
memAddr  output  DATA_W  memory address
memWdata  output  DATA_W  write data
memRdata  input  DATA_W  read data, valid while memAck=1
memAck  input  1  access complete
stall  output  1  hold PC/IF/ID/EX and EX/MEM this cycle
memErr  output  1  one-cycle pulse on aborted access
readDataOut, ALUResOut, nextPCOut  output  DATA_W  MEM/WB registered values
writeRegOut  output  REG_W  MEM/WB destination
regWriteOut, memToRegOut  output  1  MEM/WB control

Behaviour:
- FSM has two states, IDLE and WAIT.
- Reset:
  - State goes to IDLE and the wait counter clears.
  - Every registered output resets to 0, including memErr and all MEM/WB outputs.
  - memReq is forced 0 immediately (asynchronous), including when reset hits during WAIT.
- IDLE with memRead=memWrite=0:
  - No request is issued and stall=0.
  - MEM/WB loads the inputs on the next edge, with readDataOut=0. Latency is 1 cycle.
- IDLE with memRead or memWrite=1:
  - memReq=1 combinationally in the same cycle.
  - memWe=memWrite, memAddr=ALURes, memWdata=readData2.
  - If both memRead and memWrite are set, the write wins and readDataOut=0.
  - Next state is WAIT.
  - stall = memReq & ~memAck. An ack in the issue cycle completes the access in 1 cycle.
- WAIT:
  - memReq stays 1 and addr/data/we are held from the upstream registers. Upstream is frozen by stall, so these are stable.
  - The counter increments each cycle.
  - On memAck:
    - readDataOut captures memRdata (reads only) and MEM/WB loads.
    - stall=0 in the ack cycle and the state returns to IDLE. memReq is 0 on the following cycle unless a new memory op is presented.
- Bubble rule: on every edge where stall=1, MEM/WB loads a bubble (regWriteOut=0, memToRegOut=0). The other fields are don't-care, but the implementation holds them.
- Timeout:
  - Triggers when the counter reaches MAX_WAIT with no ack.
  - Effects:
    - memErr pulses for 1 cycle.
    - memReq drops.
    - The instruction retires with regWriteOut=0.
    - stall releases in that cycle.
    - State returns to IDLE and the counter clears.
- memAck while memReq=0 is ignored.
- Back-to-back memory ops: the second request may assert in the cycle after the first ack. There is no idle gap requirement.

Optional Feature:
Macro MEM_ALIGN_CHK_EN.
- Defined:
  - A memory op with ALURes[0]=1 issues no request and stays in IDLE.
  - memErr pulses 1 cycle and MEM/WB loads with regWriteOut=0.
  - There is no stall.
- Undefined: the address is passed through unchecked and memErr comes only from timeout.

Decomposition:
- Shared package (pipe_pkg) holds:
  - DATA_W and REG_W
  - FSM state encoding (IDLE=1'b0, WAIT=1'b1)
  - the MEM/WB bubble value constant
- Natural sub-module: mem_wb_reg. This is the MEM/WB register bank built from dff instances with load/bubble select, the same style as the EX/MEM register.
- FSM, counter and handshake stay in mem_access_stage.

Test Plan:
1. Non-memory op, ALURes=0x1234, regWrite=1, writeReg=3 → no memReq, stall=0; next cycle ALUResOut=0x1234, regWriteOut=1, writeRegOut=3, readDataOut=0.
2. Load, ALURes=0x0040, memAck after 3 cycles with memRdata=0xBEEF → memReq high 4 cycles, stall high 3 cycles, regWriteOut=0 during the stall; then readDataOut=0xBEEF, memToRegOut=1.
3. Store with a same-cycle ack, readData2=0x00A5, ALURes=0x0010 → memWe=1, memWdata=0x00A5, stall=0, one-cycle completion.
4. Load with memAck never asserted → memReq drops after MAX_WAIT=15 WAIT cycles, memErr=1 for exactly 1 cycle, regWriteOut=0, FSM back in IDLE.
5. Reset asserted mid-WAIT → memReq, stall and all outputs 0 asynchronously. After release, the next load completes normally.
6. With MEM_ALIGN_CHK_EN defined, a load at ALURes=0x0041 → no memReq, memErr pulse, regWriteOut=0. Without the macro, memAddr=0x0041 is issued.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline memory-access stage.
// Holds the datapath/register-index widths, the memory FSM state encoding,
// the MEM/WB boundary record and the control value loaded for a bubble.
package pipe_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] next_pc;
        logic [REG_W-1:0]  write_reg;
        logic              reg_write;
        logic              mem_to_reg;
    } mem_wb_t;

    // {reg_write, mem_to_reg} for a bubble: nothing is written back
    localparam logic [1:0] MEM_WB_BUBBLE_CTRL = 2'b00;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register bank.
//   dff        : generic W-bit register, async active-high reset to 0
//   mem_wb_reg : one dff per MEM/WB field. When bubble=1 the data fields
//                hold and the control fields load MEM_WB_BUBBLE_CTRL;
//                otherwise every field loads d_in.
// Ports (mem_wb_reg): clk, rst, bubble, d_in (mem_wb_t), q_out (mem_wb_t)
import pipe_pkg::*;

module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end
endmodule

module mem_wb_reg (
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble,
    input  mem_wb_t d_in,
    output mem_wb_t q_out
);
    mem_wb_t           d_sel;
    logic [DATA_W-1:0] read_data_q;
    logic [DATA_W-1:0] alu_res_q;
    logic [DATA_W-1:0] next_pc_q;
    logic [REG_W-1:0]  write_reg_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;

    always_comb begin
        d_sel = d_in;
        if (bubble) begin
            d_sel            = q_out;
            d_sel.reg_write  = MEM_WB_BUBBLE_CTRL[1];
            d_sel.mem_to_reg = MEM_WB_BUBBLE_CTRL[0];
        end
    end

    dff #(.W(DATA_W)) u_read_data  (.clk(clk), .rst(rst), .d(d_sel.read_data),  .q(read_data_q));
    dff #(.W(DATA_W)) u_alu_res    (.clk(clk), .rst(rst), .d(d_sel.alu_res),    .q(alu_res_q));
    dff #(.W(DATA_W)) u_next_pc    (.clk(clk), .rst(rst), .d(d_sel.next_pc),    .q(next_pc_q));
    dff #(.W(REG_W))  u_write_reg  (.clk(clk), .rst(rst), .d(d_sel.write_reg),  .q(write_reg_q));
    dff #(.W(1))      u_reg_write  (.clk(clk), .rst(rst), .d(d_sel.reg_write),  .q(reg_write_q));
    dff #(.W(1))      u_mem_to_reg (.clk(clk), .rst(rst), .d(d_sel.mem_to_reg), .q(mem_to_reg_q));

    assign q_out = '{read_data:  read_data_q,
                     alu_res:    alu_res_q,
                     next_pc:    next_pc_q,
                     write_reg:  write_reg_q,
                     reg_write:  reg_write_q,
                     mem_to_reg: mem_to_reg_q};
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: drives a single-port data memory over a req/ack
// handshake with variable latency, stalls upstream while an access is
// outstanding, aborts after MAX_WAIT WAIT cycles without an ack, and
// registers results into the MEM/WB boundary.
// Optional macro MEM_ALIGN_CHK_EN: a memory op at an odd address issues no
// request and retires with memErr and regWriteOut=0.
// Ports:
//   clk, rst (async, active-high)
//   EX/MEM in : readData2, ALURes, nextPC, writeReg, regWrite, memToReg,
//               memRead, memWrite
//   memory    : memReq, memWe, memAddr, memWdata (out); memRdata, memAck (in)
//   pipeline  : stall, memErr
//   MEM/WB out: readDataOut, ALUResOut, nextPCOut, writeRegOut,
//               regWriteOut, memToRegOut
//
// state | meaning
// IDLE  | no access outstanding; a memory op issues its request here
// WAIT  | request outstanding, waiting for memAck or timeout
import pipe_pkg::*;

module mem_access_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] readData2,
    input  logic [DATA_W-1:0] ALURes,
    input  logic [DATA_W-1:0] nextPC,
    input  logic [REG_W-1:0]  writeReg,
    input  logic              regWrite,
    input  logic              memToReg,
    input  logic              memRead,
    input  logic              memWrite,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memAck,
    output logic              stall,
    output logic              memErr,
    output logic [DATA_W-1:0] readDataOut,
    output logic [DATA_W-1:0] ALUResOut,
    output logic [DATA_W-1:0] nextPCOut,
    output logic [REG_W-1:0]  writeRegOut,
    output logic              regWriteOut,
    output logic              memToRegOut
);
    // counter value in the last WAIT cycle before the access is abandoned
    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    mem_state_e state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic       mem_op, align_err, timeout, req;
    mem_wb_t    wb_in, wb_q;

    assign mem_op = memRead | memWrite;

`ifdef MEM_ALIGN_CHK_EN
    assign align_err = mem_op & ALURes[0];
`else
    assign align_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            memErr   <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            memErr   <= timeout | align_err;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;
        req           = 1'b0;
        timeout       = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && !align_err) begin
                    req = 1'b1;
                    if (!memAck) state_next = WAIT;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (memAck) begin
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // reset must silence the memory interface immediately, even mid-access
    assign memReq   = req & ~rst;
    assign memWe    = memReq & memWrite;
    assign memAddr  = memReq ? ALURes    : '0;
    assign memWdata = memReq ? readData2 : '0;
    // an abort releases the pipeline in the same cycle it is detected
    assign stall    = memReq & ~memAck & ~timeout;

    always_comb begin
        wb_in            = '0;
        // write wins when both read and write are set, so no load data then
        wb_in.read_data  = (memReq && memAck && memRead && !memWrite) ? memRdata : '0;
        wb_in.alu_res    = ALURes;
        wb_in.next_pc    = nextPC;
        wb_in.write_reg  = writeReg;
        wb_in.reg_write  = regWrite & ~timeout & ~align_err;
        wb_in.mem_to_reg = memToReg & ~timeout & ~align_err;
    end

    mem_wb_reg u_mem_wb (
        .clk   (clk),
        .rst   (rst),
        .bubble(stall),
        .d_in  (wb_in),
        .q_out (wb_q)
    );

    assign readDataOut = wb_q.read_data;
    assign ALUResOut   = wb_q.alu_res;
    assign nextPCOut   = wb_q.next_pc;
    assign writeRegOut = wb_q.write_reg;
    assign regWriteOut = wb_q.reg_write;
    assign memToRegOut = wb_q.mem_to_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. Expected behaviour comes from a
// per-transaction model: an op with ack latency L keeps memReq high for
// min(L, MAX_WAIT)+1 cycles, stalls in all but the last of them, and aborts
// when L exceeds MAX_WAIT.
module tb_mem_access_stage;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] readData2, ALURes, nextPC, memRdata, memAddr, memWdata;
    logic [15:0] readDataOut, ALUResOut, nextPCOut;
    logic [2:0]  writeReg, writeRegOut;
    logic        regWrite, memToReg, memRead, memWrite;
    logic        memReq, memWe, memAck, stall, memErr, regWriteOut, memToRegOut;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .readData2(readData2), .ALURes(ALURes), .nextPC(nextPC),
        .writeReg(writeReg), .regWrite(regWrite), .memToReg(memToReg),
        .memRead(memRead), .memWrite(memWrite),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .memAck(memAck),
        .stall(stall), .memErr(memErr),
        .readDataOut(readDataOut), .ALUResOut(ALUResOut), .nextPCOut(nextPCOut),
        .writeRegOut(writeRegOut), .regWriteOut(regWriteOut), .memToRegOut(memToRegOut)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] npc, input logic [2:0] wreg);
        memRead = rd; memWrite = wr; regWrite = rw; memToReg = m2r;
        ALURes = addr; readData2 = wdata; nextPC = npc; writeReg = wreg;
    endtask

    // One memory op with ack arriving `lat` cycles after the issue cycle.
    task automatic do_mem_op(input logic rd, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] rdata,
                             input int lat, input logic rw, input logic m2r,
                             input logic [15:0] npc, input logic [2:0] wreg);
        bit          to;
        int          last;
        logic        exp_stall;
        logic [15:0] exp_rd;
        to   = (lat > MAX_WAIT);
        last = to ? MAX_WAIT : lat;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            drive(rd, wr, rw, m2r, addr, wdata, npc, wreg);
            memAck   = (c == lat);
            memRdata = (c == lat) ? rdata : 16'($urandom);
            #1;
            exp_stall = (c != last);
            total++;
            if (memReq !== 1'b1) begin bad++; $display("FAIL op_memReq cyc=%0d got=%b exp=1", c, memReq); end
            total++;
            if (stall !== exp_stall) begin bad++; $display("FAIL op_stall cyc=%0d got=%b exp=%b", c, stall, exp_stall); end
            total++;
            if (memAddr !== addr || memWe !== wr) begin
                bad++; $display("FAIL op_addr_we cyc=%0d got=%h/%b exp=%h/%b", c, memAddr, memWe, addr, wr);
            end
            if (wr) begin
                total++;
                if (memWdata !== wdata) begin bad++; $display("FAIL op_wdata got=%h exp=%h", memWdata, wdata); end
            end
            @(posedge clk); #1;
            if (c != last) begin
                total++;
                if (regWriteOut !== 1'b0 || memToRegOut !== 1'b0) begin
                    bad++; $display("FAIL op_bubble cyc=%0d got=%b%b exp=00", c, regWriteOut, memToRegOut);
                end
            end
        end
        memAck = 1'b0;
        exp_rd = (rd && !wr && !to) ? rdata : 16'h0000;
        total++;
        if (readDataOut !== exp_rd) begin bad++; $display("FAIL op_readData got=%h exp=%h", readDataOut, exp_rd); end
        total++;
        if (ALUResOut !== addr || nextPCOut !== npc || writeRegOut !== wreg) begin
            bad++; $display("FAIL op_fields got=%h/%h/%0d exp=%h/%h/%0d", ALUResOut, nextPCOut, writeRegOut, addr, npc, wreg);
        end
        total++;
        if (regWriteOut !== (rw && !to)) begin bad++; $display("FAIL op_regWrite got=%b exp=%b", regWriteOut, rw && !to); end
        total++;
        if (memErr !== to) begin bad++; $display("FAIL op_memErr got=%b exp=%b", memErr, to); end
        if (!to) begin
            total++;
            if (memToRegOut !== m2r) begin bad++; $display("FAIL op_memToReg got=%b exp=%b", memToRegOut, m2r); end
        end
    endtask

    // idle cycle: no request, no stall; checks the one-cycle memErr pulse ended
    task automatic idle_cycle();
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        memAck = 1'b0;
        #1;
        total++;
        if (memReq !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL idle_req_stall got=%b%b exp=00", memReq, stall); end
        @(posedge clk); #1;
        total++;
        if (memErr !== 1'b0) begin bad++; $display("FAIL idle_memErr got=%b exp=0", memErr); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        memAck = 1'b0; memRdata = 16'h0;
        #12;
        total++;
        if ({memReq, stall, memErr, regWriteOut, memToRegOut} !== 5'b0 ||
            {readDataOut, ALUResOut, nextPCOut, writeRegOut} !== 51'b0) begin
            bad++; $display("FAIL reset_outputs got=%b%b%b %h %h", memReq, stall, memErr, readDataOut, ALUResOut);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_non_mem();
        logic [15:0] a, n;
        logic [2:0]  w;
        logic        rw, m2r;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); n = 16'($urandom); w = 3'($urandom); rw = 1'($urandom); m2r = 1'($urandom);
            if (i == 0) begin a = 16'h1234; rw = 1'b1; w = 3'd3; end
            @(negedge clk);
            drive(1'b0, 1'b0, rw, m2r, a, 16'($urandom), n, w);
            memAck = 1'($urandom);  // ack without a request must be ignored
            memRdata = 16'($urandom);
            #1;
            total++;
            if (memReq !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL nonmem_req_stall got=%b%b exp=00", memReq, stall); end
            @(posedge clk); #1;
            total++;
            if (ALUResOut !== a || nextPCOut !== n || writeRegOut !== w) begin
                bad++; $display("FAIL nonmem_fields got=%h/%h/%0d exp=%h/%h/%0d", ALUResOut, nextPCOut, writeRegOut, a, n, w);
            end
            total++;
            if (regWriteOut !== rw || memToRegOut !== m2r || readDataOut !== 16'h0) begin
                bad++; $display("FAIL nonmem_ctrl got=%b%b/%h exp=%b%b/0000", regWriteOut, memToRegOut, readDataOut, rw, m2r);
            end
        end
        memAck = 1'b0;
    endtask

    task automatic test_load_latency();
        do_mem_op(1'b1, 1'b0, 16'h0040, 16'h0, 16'hBEEF, 3, 1'b1, 1'b1, 16'h0102, 3'd5);
        do_mem_op(1'b1, 1'b0, 16'h0062, 16'h0, 16'h1357, MAX_WAIT, 1'b1, 1'b1, 16'h0104, 3'd6);
    endtask

    task automatic test_store_same_cycle();
        do_mem_op(1'b0, 1'b1, 16'h0010, 16'h00A5, 16'hFFFF, 0, 1'b0, 1'b0, 16'h0200, 3'd0);
        // read and write together: the write wins, no load data retires
        do_mem_op(1'b1, 1'b1, 16'h0020, 16'h5A5A, 16'hC0DE, 1, 1'b0, 1'b0, 16'h0202, 3'd1);
    endtask

    task automatic test_back_to_back();
        logic rd, wr;
        for (int i = 0; i < 10; i++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            do_mem_op(rd, wr, 16'($urandom) & 16'hFFFE, 16'($urandom), 16'($urandom),
                      int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom),
                      16'($urandom), 3'($urandom));
        end
        idle_cycle();
    endtask

    task automatic test_timeout();
        do_mem_op(1'b1, 1'b0, 16'h0080, 16'h0, 16'hDEAD, 1000, 1'b1, 1'b1, 16'h0300, 3'd2);
        idle_cycle();
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h00C0, 16'h0, 16'h0400, 3'd7);
        memAck = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (memReq !== 1'b0 || stall !== 1'b0 || memWe !== 1'b0 || memAddr !== 16'h0) begin
            bad++; $display("FAIL rstwait_mem got=%b%b%b/%h exp=000/0000", memReq, stall, memWe, memAddr);
        end
        total++;
        if ({memErr, regWriteOut, memToRegOut} !== 3'b0 ||
            {readDataOut, ALUResOut, nextPCOut, writeRegOut} !== 51'b0) begin
            bad++; $display("FAIL rstwait_regs got=%b%b%b %h %h %h %0d", memErr, regWriteOut, memToRegOut,
                            readDataOut, ALUResOut, nextPCOut, writeRegOut);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 3'd0);
        rst = 1'b0;
        do_mem_op(1'b1, 1'b0, 16'h00C2, 16'h0, 16'h4321, 2, 1'b1, 1'b1, 16'h0402, 3'd4);
    endtask

    task automatic test_align();
`ifdef MEM_ALIGN_CHK_EN
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0041, 16'h0, 16'h0500, 3'd3);
        memAck = 1'b0;
        #1;
        total++;
        if (memReq !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL align_req_stall got=%b%b exp=00", memReq, stall); end
        @(posedge clk); #1;
        total++;
        if (memErr !== 1'b1 || regWriteOut !== 1'b0) begin
            bad++; $display("FAIL align_err got=%b/%b exp=1/0", memErr, regWriteOut);
        end
        idle_cycle();
`else
        do_mem_op(1'b1, 1'b0, 16'h0041, 16'h0, 16'h7777, 1, 1'b1, 1'b1, 16'h0500, 3'd3);
`endif
    endtask

    initial begin
        test_reset();
        test_non_mem();
        test_load_latency();
        test_store_same_cycle();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        test_align();
        idle_cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
